// File: rtl/tx_arbiter.sv
// Arbitrates one TX serializer between the prefetch and scheduler requesters,
// and tracks which requester owns each outstanding RX reply (2-entry FIFO).
module tx_arbiter #(
    parameter int NSHIFT   = 2,
    parameter int CMD_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                pf_req,
    input  logic [CMD_BITS-1:0] pf_cmd,
    input  logic                pf_reply,
    input  logic [NSHIFT-1:0]   pf_data,
    output logic                pf_grant,
    output logic                pf_data_next,

    input  logic                sc_req,
    input  logic [CMD_BITS-1:0] sc_cmd,
    input  logic                sc_reply,
    input  logic [NSHIFT-1:0]   sc_data,
    input  logic                sc_reserve,
    output logic                sc_grant,
    output logic                sc_data_next,

    output logic                tx_command_valid,
    output logic [CMD_BITS-1:0] tx_command,
    output logic [NSHIFT-1:0]   tx_data,
    input  logic                tx_command_started,
    input  logic                tx_data_next,
    input  logic                tx_done,

    input  logic                rx_done,
    output logic                reply_to_pf,
    output logic                reply_to_sc,
    output logic                busy,
    output logic                reply_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PF_TX = 2'd1,
        SC_TX = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] fifo_q, fifo_d;      // owner bits, entry 0 is the head; 1 = scheduler
    logic [1:0] count_q, count_d;
    logic       reply_err_q, reply_err_d;

    logic       pf_slot, sc_slot;
    logic       sel_pf, sel_sc;
    logic       start, push, pop;
    logic [1:0] count_after_pop;

    // Selection is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        pf_slot = !pf_reply || (count_q != 2'd2);
        sc_slot = !sc_reply || (count_q != 2'd2);
        sel_sc  = rst_n && (state_q == IDLE) && sc_req && sc_slot;
        sel_pf  = rst_n && (state_q == IDLE) && pf_req && !sc_req && !sc_reserve && pf_slot;
        start   = (sel_sc || sel_pf) && tx_command_started;
        push    = start && (sel_sc ? sc_reply : pf_reply);
        pop     = rx_done && (count_q != 2'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_sc && tx_command_started)      state_d = SC_TX;
                else if (sel_pf && tx_command_started) state_d = PF_TX;
            end
            PF_TX, SC_TX: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop shifts the head out first, so a simultaneous push lands behind any survivor.
    always_comb begin
        fifo_d          = fifo_q;
        count_after_pop = count_q - {1'b0, pop};
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = 1'b0;
        end
        if (push) begin
            if (count_after_pop == 2'd1) fifo_d[1] = sel_sc;
            else                         fifo_d[0] = sel_sc;
        end
        count_d     = count_after_pop + {1'b0, push};
        reply_err_d = reply_err_q || (rx_done && (count_q == 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fifo_q      <= '0;
            count_q     <= '0;
            reply_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            reply_err_q <= reply_err_d;
        end
    end

    always_comb begin
        tx_command_valid = sel_sc || sel_pf;
        if (sel_sc)      tx_command = sc_cmd;
        else if (sel_pf) tx_command = pf_cmd;
        else             tx_command = '0;

        pf_grant = sel_pf && tx_command_started;
        sc_grant = sel_sc && tx_command_started;

        case (state_q)
            PF_TX:   tx_data = pf_data;
            SC_TX:   tx_data = sc_data;
            default: tx_data = '0;
        endcase
        pf_data_next = (state_q == PF_TX) && tx_data_next;
        sc_data_next = (state_q == SC_TX) && tx_data_next;

        reply_to_pf = (count_q != 2'd0) && !fifo_q[0];
        reply_to_sc = (count_q != 2'd0) &&  fifo_q[0];
        busy        = (state_q != IDLE);
        reply_err   = reply_err_q;
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_tx_arbiter;

    localparam int NSHIFT   = 2;
    localparam int CMD_BITS = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pf_req, pf_reply, sc_req, sc_reply, sc_reserve;
    logic [CMD_BITS-1:0] pf_cmd, sc_cmd;
    logic [NSHIFT-1:0]   pf_data, sc_data;
    logic                tx_command_started, tx_data_next, tx_done, rx_done;
    logic                pf_grant, pf_data_next, sc_grant, sc_data_next;
    logic                tx_command_valid;
    logic [CMD_BITS-1:0] tx_command;
    logic [NSHIFT-1:0]   tx_data;
    logic                reply_to_pf, reply_to_sc, busy, reply_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tx_arbiter #(.NSHIFT(NSHIFT), .CMD_BITS(CMD_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .pf_req(pf_req), .pf_cmd(pf_cmd), .pf_reply(pf_reply), .pf_data(pf_data),
        .pf_grant(pf_grant), .pf_data_next(pf_data_next),
        .sc_req(sc_req), .sc_cmd(sc_cmd), .sc_reply(sc_reply), .sc_data(sc_data),
        .sc_reserve(sc_reserve), .sc_grant(sc_grant), .sc_data_next(sc_data_next),
        .tx_command_valid(tx_command_valid), .tx_command(tx_command), .tx_data(tx_data),
        .tx_command_started(tx_command_started), .tx_data_next(tx_data_next),
        .tx_done(tx_done), .rx_done(rx_done),
        .reply_to_pf(reply_to_pf), .reply_to_sc(reply_to_sc),
        .busy(busy), .reply_err(reply_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: who owns the channel (0 none, 1 prefetch, 2 scheduler)
    // and a queue of reply owners (1 = scheduler), oldest first.
    int m_owner = 0;
    bit m_q[$];
    bit m_err   = 1'b0;

    function automatic int sel_f();
        if (!rst_n || m_owner != 0) return 0;
        if (sc_req && (!sc_reply || m_q.size() < 2)) return 2;
        if (pf_req && !sc_req && !sc_reserve && (!pf_reply || m_q.size() < 2)) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_q.delete();
            m_err   <= 1'b0;
        end else begin
            int s;
            s = sel_f();
            if (rx_done) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else                m_err <= 1'b1;
            end
            if (m_owner != 0) begin
                if (tx_done) m_owner <= 0;
            end else if (s != 0 && tx_command_started) begin
                if ((s == 2) ? sc_reply : pf_reply) m_q.push_back(s == 2);
                m_owner <= s;
            end
        end
    end

    always @(negedge clk) begin
        int s;
        logic [CMD_BITS-1:0] e_cmd;
        logic [NSHIFT-1:0]   e_data;
        s      = sel_f();
        e_cmd  = (s == 2) ? sc_cmd : (s == 1) ? pf_cmd : '0;
        e_data = (m_owner == 1) ? pf_data : (m_owner == 2) ? sc_data : '0;
        chk("m_valid",    32'(tx_command_valid), 32'(s != 0));
        chk("m_cmd",      32'(tx_command),       32'(e_cmd));
        chk("m_pf_grant", 32'(pf_grant),         32'(s == 1 && tx_command_started));
        chk("m_sc_grant", 32'(sc_grant),         32'(s == 2 && tx_command_started));
        chk("m_tx_data",  32'(tx_data),          32'(e_data));
        chk("m_pf_dnext", 32'(pf_data_next),     32'(m_owner == 1 && tx_data_next));
        chk("m_sc_dnext", 32'(sc_data_next),     32'(m_owner == 2 && tx_data_next));
        chk("m_rep_pf",   32'(reply_to_pf),      32'(m_q.size() > 0 && m_q[0] == 1'b0));
        chk("m_rep_sc",   32'(reply_to_sc),      32'(m_q.size() > 0 && m_q[0] == 1'b1));
        chk("m_busy",     32'(busy),             32'(m_owner != 0));
        chk("m_err",      32'(reply_err),        32'(m_err));
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pf_req = 1'b1; pf_cmd = '0; pf_reply = 1'b0; pf_data = '0;
        sc_req = 1'b0; sc_cmd = '0; sc_reply = 1'b0; sc_data = '0; sc_reserve = 1'b0;
        tx_command_started = 1'b0; tx_data_next = 1'b0; tx_done = 1'b0; rx_done = 1'b0;

        // Held in reset with a request pending: nothing offered.
        repeat (3) nxt();
        mid(); chk("rst_valid", 32'(tx_command_valid), 0); chk("rst_busy", 32'(busy), 0);

        // Prefetch command 2 with reply.
        nxt(); rst_n = 1'b1; pf_cmd = 2'd2; pf_reply = 1'b1;
        mid(); chk("pf_offer_valid", 32'(tx_command_valid), 1); chk("pf_offer_cmd", 32'(tx_command), 2);
        chk("pf_no_grant_yet", 32'(pf_grant), 0);
        nxt(); tx_command_started = 1'b1;
        mid(); chk("pf_grant", 32'(pf_grant), 1);
        nxt(); pf_req = 1'b0; tx_command_started = 1'b0; pf_data = 2'd3; tx_data_next = 1'b1;
        mid(); chk("pf_busy", 32'(busy), 1); chk("pf_reply_owner", 32'(reply_to_pf), 1);
        chk("pf_grant_pulse", 32'(pf_grant), 0); chk("pf_txdata", 32'(tx_data), 3);
        chk("pf_dnext", 32'(pf_data_next), 1);
        nxt(); tx_done = 1'b1; tx_data_next = 1'b0;
        nxt(); tx_done = 1'b0;

        // Started with nothing offered is ignored.
        tx_command_started = 1'b1;
        nxt(); mid(); chk("stray_start_idle", 32'(busy), 0);
        nxt(); tx_command_started = 1'b0;

        // Simultaneous requests: scheduler first.
        pf_req = 1'b1; pf_reply = 1'b0; pf_cmd = 2'd1;
        sc_req = 1'b1; sc_reply = 1'b1; sc_cmd = 2'd3; tx_command_started = 1'b1;
        mid(); chk("prio_sc_grant", 32'(sc_grant), 1); chk("prio_pf_wait", 32'(pf_grant), 0);
        chk("prio_cmd", 32'(tx_command), 3);
        nxt(); sc_req = 1'b0; sc_data = 2'd2; tx_data_next = 1'b1;
        mid(); chk("sctx_no_pf", 32'(pf_grant), 0); chk("sctx_valid", 32'(tx_command_valid), 0);
        chk("sctx_dnext", 32'(sc_data_next), 1); chk("sctx_pf_dnext", 32'(pf_data_next), 0);
        nxt(); tx_done = 1'b1; tx_data_next = 1'b0;
        mid(); chk("done_cycle_no_pf", 32'(pf_grant), 0);
        nxt(); tx_done = 1'b0;
        mid(); chk("pf_after_done", 32'(pf_grant), 1); chk("pf_after_cmd", 32'(tx_command), 1);
        nxt(); pf_req = 1'b0; tx_command_started = 1'b0;
        nxt(); tx_done = 1'b1;
        nxt(); tx_done = 1'b0;

        // Reply queue full (pf, sc): reply-bearing request blocked until rx_done.
        sc_req = 1'b1; sc_reply = 1'b1; sc_cmd = 2'd2; tx_command_started = 1'b1;
        repeat (3) begin
            mid(); chk("full_valid", 32'(tx_command_valid), 0); chk("full_grant", 32'(sc_grant), 0);
            nxt();
        end
        rx_done = 1'b1;
        mid(); chk("full_pop_cycle", 32'(tx_command_valid), 0);
        nxt(); rx_done = 1'b0;
        mid(); chk("pop_head_sc", 32'(reply_to_sc), 1); chk("pop_head_not_pf", 32'(reply_to_pf), 0);
        chk("unblocked_grant", 32'(sc_grant), 1);
        nxt(); sc_req = 1'b0; tx_command_started = 1'b0; tx_done = 1'b1;
        nxt(); tx_done = 1'b0; rx_done = 1'b1;
        // Push and pop in the same cycle.
        nxt(); pf_req = 1'b1; pf_reply = 1'b1; pf_cmd = 2'd0; tx_command_started = 1'b1;
        mid(); chk("pushpop_grant", 32'(pf_grant), 1);
        nxt(); pf_req = 1'b0; tx_command_started = 1'b0; rx_done = 1'b0;
        mid(); chk("pushpop_head_pf", 32'(reply_to_pf), 1); chk("pushpop_busy", 32'(busy), 1);
        nxt(); tx_done = 1'b1;
        nxt(); tx_done = 1'b0; rx_done = 1'b1;
        nxt(); rx_done = 1'b0;
        mid(); chk("empty_rep_pf", 32'(reply_to_pf), 0); chk("empty_rep_sc", 32'(reply_to_sc), 0);
        chk("empty_no_err", 32'(reply_err), 0);

        // Reservation blocks prefetch.
        sc_reserve = 1'b1; pf_req = 1'b1; pf_reply = 1'b0; pf_cmd = 2'd3;
        repeat (10) begin
            mid(); chk("reserve_blocks", 32'(tx_command_valid), 0);
            nxt();
        end
        sc_reserve = 1'b0;
        mid(); chk("reserve_drop_valid", 32'(tx_command_valid), 1); chk("reserve_drop_cmd", 32'(tx_command), 3);
        nxt(); pf_req = 1'b0;

        // rx_done on an empty queue: sticky error cleared only by reset.
        rx_done = 1'b1;
        nxt(); rx_done = 1'b0;
        mid(); chk("err_set", 32'(reply_err), 1);
        repeat (3) nxt();
        mid(); chk("err_sticky", 32'(reply_err), 1);
        rst_n = 1'b0;
        nxt(); mid(); chk("err_cleared", 32'(reply_err), 0);
        nxt(); rst_n = 1'b1;

        // Reset in the middle of a scheduler transaction.
        sc_req = 1'b1; sc_reply = 1'b1; sc_cmd = 2'd1; tx_command_started = 1'b1;
        nxt(); tx_command_started = 1'b0;
        mid(); chk("sctx_busy", 32'(busy), 1); chk("sctx_rep_sc", 32'(reply_to_sc), 1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0); chk("async_rep_sc", 32'(reply_to_sc), 0);
        chk("async_valid", 32'(tx_command_valid), 0);
        nxt(); rst_n = 1'b1; sc_req = 1'b0;
        nxt(); nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NSHIFT, default 2, bits per serial cycle for data and payload.
REQ-002 Parameter CMD_BITS, default 2, width of a TX command.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pf_req  input  1  prefetch requests a TX command; held until pf_grant.
REQ-006 pf_cmd  input  CMD_BITS  prefetch command.
REQ-007 pf_reply  input  1  prefetch command expects an RX reply.
REQ-008 pf_data  input  NSHIFT  prefetch payload bits.
REQ-009 pf_grant  output  1  one-cycle pulse: prefetch command started.
REQ-010 pf_data_next  output  1  prefetch advances payload.
REQ-011 sc_req, sc_cmd, sc_reply, sc_data  inputs  1/CMD_BITS/1/NSHIFT  scheduler request, same meaning as pf_*.
REQ-012 sc_reserve  input  1  scheduler reserves the channel; blocks new prefetch grants.
REQ-013 sc_grant, sc_data_next  outputs  1/1  scheduler equivalents of pf_grant, pf_data_next.
REQ-014 tx_command_valid  output  1  command offered to TX serializer.
REQ-015 tx_command  output  CMD_BITS  offered command.
REQ-016 tx_data  output  NSHIFT  payload to serializer.
REQ-017 tx_command_started  input  1  serializer accepted the offered command this cycle.
REQ-018 tx_data_next, tx_done  inputs  1/1  serializer payload advance; transaction finished.
REQ-019 rx_done  input  1  one RX reply fully received.
REQ-020 reply_to_pf, reply_to_sc  outputs  1/1  owner of the oldest outstanding reply (combinational from queue head).
REQ-021 busy  output  1  state is not IDLE.
REQ-022 reply_err  output  1  sticky: rx_done seen with empty reply queue.

Function
REQ-023 States IDLE, PF_TX, SC_TX; reply queue: 2-entry FIFO of owner bits plus 2-bit count (0..2).
REQ-024 slot_ok(x) = !x_reply || count<2.
REQ-025 IDLE selection: sc if sc_req && slot_ok(sc); else pf if pf_req && !sc_req && !sc_reserve && slot_ok(pf); else none.
REQ-026 IDLE: tx_command_valid = a requester is selected; tx_command = selected cmd; tx_command = 0 when none.
REQ-027 IDLE && tx_command_started: selected grant pulses same cycle; state -> PF_TX/SC_TX next cycle; owner pushed if its reply bit set.
REQ-028 tx_command_started while tx_command_valid=0: ignored, state unchanged.
REQ-029 PF_TX/SC_TX: tx_command_valid=0; tx_data = owner's data; owner's data_next = tx_data_next; other data_next=0.
REQ-030 tx_done in PF_TX/SC_TX: -> IDLE next cycle; new grant earliest the cycle after; tx_done in IDLE ignored.
REQ-031 IDLE: tx_data = 0; both data_next = 0.
REQ-032 rx_done with count>0 pops head; push and pop same cycle: count unchanged, FIFO order preserved.
REQ-033 rx_done with count=0: no pop, reply_err set until reset.
REQ-034 reply_to_pf/reply_to_sc both 0 when count=0; exactly one high otherwise.
REQ-035 Fixed priority sc > pf; sc_reserve without sc_req leaves channel idle.

Reset
REQ-036 rst_n low at any time, including mid-transaction: state IDLE, count 0, reply_err 0, all outputs 0 while low and after release until new request.
REQ-037 First grant possible in the first clock edge after rst_n deasserts.

Verification
REQ-038 pf_req=1, pf_cmd=2, pf_reply=1, tx_command_started next cycle -> tx_command=2, pf_grant 1 cycle, state PF_TX, reply_to_pf=1 after.
REQ-039 pf_req and sc_req same cycle -> sc_grant first; pf granted only after tx_done returns to IDLE.
REQ-040 Two reply-bearing grants (pf then sc), count=2, third sc_reply request -> tx_command_valid=0 until rx_done; first rx_done -> reply_to_sc=1.
REQ-041 sc_reserve=1, sc_req=0, pf_req=1 -> tx_command_valid=0 for 10 cycles; drop sc_reserve -> pf offered next cycle.
REQ-042 rx_done with count=0 -> reply_err=1, stays 1; rst_n pulse -> 0.
REQ-043 rst_n low during SC_TX with count=1 -> busy=0, reply_to_sc=0, tx_command_valid=0 immediately.
